// File: rtl/seg8_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver (active-low segments and selects).
// Shows a 32-bit word captured only at frame boundaries, so a frame never tears.
module seg8_scan_driver #(
  parameter int SCAN_DIV   = 16384,
  parameter bit LEAD_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [31:0] i_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [2:0]    dig;
  logic [31:0]   snap;

  logic          tick;
  logic          frame_end;
  logic [2:0]    next_dig;
  logic [4:0]    nib_lsb;
  logic [31:0]   src;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    next_seg;
  logic [7:0]    next_sel;

  function automatic logic [7:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 8'hC0;
      4'h1: dec = 8'hF9;
      4'h2: dec = 8'hA4;
      4'h3: dec = 8'hB0;
      4'h4: dec = 8'h99;
      4'h5: dec = 8'h92;
      4'h6: dec = 8'h82;
      4'h7: dec = 8'hF8;
      4'h8: dec = 8'h80;
      4'h9: dec = 8'h90;
      4'hA: dec = 8'h88;
      4'hB: dec = 8'h83;
      4'hC: dec = 8'hC6;
      4'hD: dec = 8'hA1;
      4'hE: dec = 8'h86;
      default: dec = 8'h8E;
    endcase
  endfunction

  assign tick      = (div_cnt == LAST);
  assign frame_end = tick && (dig == 3'd7);
  assign next_dig  = dig + 3'd1;
  assign nib_lsb   = {next_dig, 2'b00};

  // Digit 0 of a new frame is decoded from the value being captured, not the stale snapshot.
  always_comb begin
    src      = snap;
    if (frame_end && cs) src = i_data;
    nib      = src[nib_lsb +: 4];
    blank    = LEAD_BLANK && (next_dig != 3'd0) && ((src >> nib_lsb) == '0);
    next_sel = 8'hFF;
    next_seg = 8'hFF;
    if (cs) begin
      next_sel = ~(8'b1 << next_dig);
      if (!blank) next_seg = dec(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      dig     <= '0;
      snap    <= '0;
      o_seg   <= 8'hFF;
      o_sel   <= 8'hFF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        dig   <= next_dig;
        o_seg <= next_seg;
        o_sel <= next_sel;
      end
      if (frame_end && cs) snap <= i_data;
    end
  end

endmodule
